// File: rtl/bnn_fc_seq.sv
// Time-multiplexed binary fully-connected layer: PAR XNOR-popcount neurons per cycle,
// weights/thresholds/signs streamed from an external memory with one cycle read latency.
module bnn_fc_seq #(
    parameter int N_IN    = 288,
    parameter int N_OUT   = 64,
    parameter int PAR     = 4,
    parameter int RAW_OUT = 0,
    localparam int CW     = $clog2(N_IN + 1),
    localparam int G      = N_OUT / PAR,
    localparam int AW     = (G > 1) ? $clog2(G) : 1,
    localparam int CLW    = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [N_IN-1:0]      layer_i,
    output logic                 w_rd_o,
    output logic [AW-1:0]        w_addr_o,
    input  logic [PAR*N_IN-1:0]  w_data_i,
    input  logic [PAR*CW-1:0]    thr_data_i,
    input  logic [PAR*2-1:0]     sign_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [N_OUT-1:0]     layer_o,
    output logic [N_OUT*CW-1:0]  count_o,
    output logic [CLW-1:0]       class_o,
    output logic [1:0]           state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // in_ready_o is high only in IDLE, out_valid_o holds with stable data until out_ready_i.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [N_IN-1:0]   x_q;
    logic              w_rd_q;
    logic [AW-1:0]     w_addr_q;
    logic              cmp_valid;
    logic [AW-1:0]     cmp_grp;
    logic [CW-1:0]     count_q [N_OUT];
    logic [N_OUT-1:0]  layer_q;
    logic [CW-1:0]     best_cnt;
    logic [CLW-1:0]    best_idx;
    logic              out_valid_q;

    logic [CW-1:0]     cnt [PAR];
    logic [PAR-1:0]    bit_v;
    logic [CW-1:0]     gbest_cnt;
    logic [CLW-1:0]    gbest_idx;

    // Datapath for the group whose memory data is on the bus this cycle.
    always_comb begin
        logic          match_b;
        logic [CW-1:0] thr_p;
        logic [1:0]    sign_p;
        for (int p = 0; p < PAR; p++) begin
            cnt[p] = '0;
            for (int i = 0; i < N_IN; i++) begin
                match_b = ~(x_q[i] ^ w_data_i[p*N_IN + i]);
                cnt[p]  = cnt[p] + CW'(match_b);
            end
            thr_p  = thr_data_i[p*CW +: CW];
            sign_p = sign_data_i[p*2 +: 2];
            case (sign_p)
                2'b01:   bit_v[p] = (cnt[p] >= thr_p);
                2'b10:   bit_v[p] = (cnt[p] <= thr_p);
                2'b11:   bit_v[p] = 1'b1;
                default: bit_v[p] = 1'b0;
            endcase
        end
    end

    // Best of this group; strict compare keeps the lowest index on ties.
    always_comb begin
        gbest_cnt = cnt[0];
        gbest_idx = CLW'(int'(cmp_grp) * PAR);
        for (int p = 1; p < PAR; p++) begin
            if (cnt[p] > gbest_cnt) begin
                gbest_cnt = cnt[p];
                gbest_idx = CLW'(int'(cmp_grp) * PAR + p);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            x_q         <= '0;
            w_rd_q      <= 1'b0;
            w_addr_q    <= '0;
            cmp_valid   <= 1'b0;
            cmp_grp     <= '0;
            layer_q     <= '0;
            best_cnt    <= '0;
            best_idx    <= '0;
            out_valid_q <= 1'b0;
            for (int n = 0; n < N_OUT; n++) begin
                count_q[n] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        x_q       <= layer_i;
                        w_rd_q    <= 1'b1;
                        w_addr_q  <= '0;
                        cmp_valid <= 1'b0;
                        cmp_grp   <= '0;
                        best_cnt  <= '0;
                        best_idx  <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    // The compute stage trails the issue stage by exactly one cycle.
                    cmp_valid <= w_rd_q;
                    cmp_grp   <= w_addr_q;
                    if (w_rd_q) begin
                        if (w_addr_q == AW'(G - 1)) begin
                            w_rd_q <= 1'b0;
                        end else begin
                            w_addr_q <= w_addr_q + AW'(1);
                        end
                    end
                    if (cmp_valid) begin
                        for (int n = 0; n < N_OUT; n++) begin
                            if (AW'(n / PAR) == cmp_grp) begin
                                count_q[n] <= cnt[n % PAR];
                                layer_q[n] <= bit_v[n % PAR];
                            end
                        end
                        if (gbest_cnt > best_cnt) begin
                            best_cnt <= gbest_cnt;
                            best_idx <= gbest_idx;
                        end
                        if (cmp_grp == AW'(G - 1)) begin
                            out_valid_q <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready_o  = (state == IDLE);
    assign w_rd_o      = w_rd_q;
    assign w_addr_o    = w_addr_q;
    assign out_valid_o = out_valid_q;
    assign layer_o     = (RAW_OUT != 0) ? '0 : layer_q;
    assign class_o     = (RAW_OUT != 0) ? best_idx : '0;
    assign state_o     = state;

    for (genvar n = 0; n < N_OUT; n++) begin : g_count
        assign count_o[n*CW +: CW] = count_q[n];
    end

endmodule

// File: tb/tb_bnn_fc_seq.sv
// Directed bench for bnn_fc_seq: a thresholded 9x4 instance and a raw 9x10 instance,
// each fed by a one-cycle-latency parameter memory model.
module tb_bnn_fc_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   checks = 0;
    int   errors = 0;

    // Instance A: N_IN=9, N_OUT=4, PAR=2, thresholded
    logic        a_in_valid, a_in_ready, a_w_rd, a_out_valid, a_out_ready;
    logic [8:0]  a_layer_in;
    logic [0:0]  a_w_addr;
    logic [17:0] a_w_data;
    logic [7:0]  a_thr;
    logic [3:0]  a_sign;
    logic [3:0]  a_layer_out;
    logic [15:0] a_count;
    logic [1:0]  a_class;
    logic [1:0]  a_state;
    logic [17:0] a_wmem [2];
    logic [7:0]  a_tmem [2];
    logic [3:0]  a_smem [2];

    // Instance B: N_IN=9, N_OUT=10, PAR=2, raw
    logic        b_in_valid, b_in_ready, b_w_rd, b_out_valid, b_out_ready;
    logic [8:0]  b_layer_in;
    logic [2:0]  b_w_addr;
    logic [17:0] b_w_data;
    logic [7:0]  b_thr;
    logic [3:0]  b_sign;
    logic [9:0]  b_layer_out;
    logic [39:0] b_count;
    logic [3:0]  b_class;
    logic [1:0]  b_state;
    logic [17:0] b_wmem [5];

    bnn_fc_seq #(.N_IN(9), .N_OUT(4), .PAR(2), .RAW_OUT(0)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .layer_i(a_layer_in),
        .w_rd_o(a_w_rd), .w_addr_o(a_w_addr), .w_data_i(a_w_data),
        .thr_data_i(a_thr), .sign_data_i(a_sign),
        .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
        .layer_o(a_layer_out), .count_o(a_count), .class_o(a_class), .state_o(a_state)
    );

    bnn_fc_seq #(.N_IN(9), .N_OUT(10), .PAR(2), .RAW_OUT(1)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .layer_i(b_layer_in),
        .w_rd_o(b_w_rd), .w_addr_o(b_w_addr), .w_data_i(b_w_data),
        .thr_data_i(b_thr), .sign_data_i(b_sign),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
        .layer_o(b_layer_out), .count_o(b_count), .class_o(b_class), .state_o(b_state)
    );

    always @(posedge clk) begin
        if (a_w_rd) begin
            a_w_data <= a_wmem[a_w_addr];
            a_thr    <= a_tmem[a_w_addr];
            a_sign   <= a_smem[a_w_addr];
        end
        if (b_w_rd) begin
            b_w_data <= b_wmem[b_w_addr];
            b_thr    <= 8'h00;
            b_sign   <= 4'b1111;
        end
    end

    task automatic a_load(input logic [8:0] w0, w1, w2, w3,
                          input logic [3:0] t0, t1, t2, t3,
                          input logic [1:0] s0, s1, s2, s3);
        a_wmem[0] = {w1, w0};
        a_wmem[1] = {w3, w2};
        a_tmem[0] = {t1, t0};
        a_tmem[1] = {t3, t2};
        a_smem[0] = {s1, s0};
        a_smem[1] = {s3, s2};
    endtask

    // Weight with the c lowest bits set: against an all-ones input it matches c bits.
    task automatic b_load(input int c0, c1, c2, c3, c4, c5, c6, c7, c8, c9);
        logic [8:0] w [10];
        int c [10];
        c = '{c0, c1, c2, c3, c4, c5, c6, c7, c8, c9};
        for (int n = 0; n < 10; n++) w[n] = 9'((1 << c[n]) - 1);
        for (int g = 0; g < 5; g++) b_wmem[g] = {w[2*g+1], w[2*g]};
    endtask

    // Leaves the caller at the falling edge just after the accept edge.
    task automatic a_start(input logic [8:0] x);
        @(negedge clk);
        a_layer_in = x;
        a_in_valid = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b0;
    endtask

    task automatic a_run(input logic [8:0] x, output logic [15:0] cnt,
                         output logic [3:0] lay, output logic ok);
        int k;
        a_out_ready = 1'b1;
        a_start(x);
        k = 0;
        while (!a_out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        ok  = a_out_valid;
        cnt = a_count;
        lay = a_layer_out;
        @(negedge clk);
    endtask

    task automatic b_run(input logic [8:0] x, output logic [39:0] cnt,
                         output logic [9:0] lay, output logic [3:0] cls, output logic ok);
        int k;
        b_out_ready = 1'b1;
        @(negedge clk);
        b_layer_in = x;
        b_in_valid = 1'b1;
        @(negedge clk);
        b_in_valid = 1'b0;
        k = 0;
        while (!b_out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        ok  = b_out_valid;
        cnt = b_count;
        lay = b_layer_out;
        cls = b_class;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL rst_a_in_ready got %b exp 1", a_in_ready); end
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_a_out_valid got %b exp 0", a_out_valid); end
        checks++; if ({a_w_rd, a_w_addr} !== 2'b00) begin errors++; $display("FAIL rst_a_w_rd_addr got %b exp 00", {a_w_rd, a_w_addr}); end
        checks++; if ({a_layer_out, a_count, a_class} !== 22'h0) begin errors++; $display("FAIL rst_a_outputs got %h exp 0", {a_layer_out, a_count, a_class}); end
        checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL rst_b_in_ready got %b exp 1", b_in_ready); end
        checks++; if ({b_out_valid, b_w_rd, b_w_addr} !== 5'b0) begin errors++; $display("FAIL rst_b_ctrl got %b exp 0", {b_out_valid, b_w_rd, b_w_addr}); end
        checks++; if ({b_layer_out, b_count, b_class} !== 54'h0) begin errors++; $display("FAIL rst_b_outputs got %h exp 0", {b_layer_out, b_count, b_class}); end
        checks++; if (a_state !== 2'd0) begin errors++; $display("FAIL rst_a_state got %0d exp 0", a_state); end
    endtask

    task automatic test_latency();
        int k;
        int rd_n;
        a_load(9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF, 4'd9, 4'd9, 4'd9, 4'd9,
               2'b01, 2'b01, 2'b01, 2'b01);
        a_out_ready = 1'b1;
        a_start(9'h1FF);
        k = 0;
        rd_n = 0;
        while (!a_out_valid && k < 50) begin
            if (a_w_rd) begin
                checks++; if (a_w_addr !== rd_n[0]) begin errors++; $display("FAIL lat_addr got %0d exp %0d", a_w_addr, rd_n); end
                rd_n++;
            end
            @(negedge clk);
            k++;
        end
        checks++; if (k !== 3) begin errors++; $display("FAIL lat_edges got %0d exp 3", k); end
        checks++; if (rd_n !== 2) begin errors++; $display("FAIL lat_rd_cycles got %0d exp 2", rd_n); end
        checks++; if (a_count !== 16'h9999) begin errors++; $display("FAIL lat_count got %h exp 9999", a_count); end
        checks++; if (a_layer_out !== 4'b1111) begin errors++; $display("FAIL lat_layer got %b exp 1111", a_layer_out); end
        checks++; if (a_class !== 2'd0) begin errors++; $display("FAIL lat_class got %0d exp 0", a_class); end
        checks++; if (a_state !== 2'd2) begin errors++; $display("FAIL lat_state got %0d exp 2", a_state); end
        @(negedge clk);
        checks++; if ({a_out_valid, a_in_ready} !== 2'b01) begin errors++; $display("FAIL lat_handshake got %b exp 01", {a_out_valid, a_in_ready}); end
    endtask

    task automatic test_sign_codes();
        logic [15:0] cnt;
        logic [3:0]  lay;
        logic        ok;
        // 5 of 9 bits match for every neuron
        a_load(9'h01F, 9'h01F, 9'h01F, 9'h01F, 4'd5, 4'd5, 4'd5, 4'd5,
               2'b01, 2'b10, 2'b00, 2'b11);
        a_run(9'h1FF, cnt, lay, ok);
        checks++; if (!ok) begin errors++; $display("FAIL sign_thr5_timeout got 0 exp 1"); end
        checks++; if (cnt !== 16'h5555) begin errors++; $display("FAIL sign_thr5_count got %h exp 5555", cnt); end
        checks++; if (lay !== 4'b1011) begin errors++; $display("FAIL sign_thr5_layer got %b exp 1011", lay); end
        a_load(9'h01F, 9'h01F, 9'h01F, 9'h01F, 4'd6, 4'd6, 4'd6, 4'd6,
               2'b01, 2'b10, 2'b00, 2'b11);
        a_run(9'h1FF, cnt, lay, ok);
        checks++; if (!ok) begin errors++; $display("FAIL sign_thr6_timeout got 0 exp 1"); end
        checks++; if (lay !== 4'b1010) begin errors++; $display("FAIL sign_thr6_layer got %b exp 1010", lay); end
    endtask

    task automatic test_pattern();
        logic [15:0] cnt;
        logic [3:0]  lay;
        logic        ok;
        // matches 9, 0, 5, 4; thresholds exercise both equality edges
        a_load(9'h0AA, 9'h155, 9'h000, 9'h1FF, 4'd9, 4'd0, 4'd4, 4'd4,
               2'b01, 2'b10, 2'b10, 2'b01);
        a_run(9'h0AA, cnt, lay, ok);
        checks++; if (!ok) begin errors++; $display("FAIL pat_timeout got 0 exp 1"); end
        checks++; if (cnt !== 16'h4509) begin errors++; $display("FAIL pat_count got %h exp 4509", cnt); end
        checks++; if (lay !== 4'b1011) begin errors++; $display("FAIL pat_layer got %b exp 1011", lay); end
    endtask

    task automatic test_raw();
        logic [39:0] cnt;
        logic [9:0]  lay;
        logic [3:0]  cls;
        logic        ok;
        b_load(3, 7, 7, 1, 0, 2, 7, 4, 5, 6);
        b_run(9'h1FF, cnt, lay, cls, ok);
        checks++; if (!ok) begin errors++; $display("FAIL raw1_timeout got 0 exp 1"); end
        checks++; if (cnt !== 40'h6547_2017_73) begin errors++; $display("FAIL raw1_count got %h exp 6547201773", cnt); end
        checks++; if (cls !== 4'd1) begin errors++; $display("FAIL raw1_class got %0d exp 1", cls); end
        checks++; if (lay !== 10'd0) begin errors++; $display("FAIL raw1_layer got %b exp 0", lay); end
        // tie at the top inside the last group
        b_load(1, 2, 3, 4, 5, 6, 7, 8, 9, 9);
        b_run(9'h1FF, cnt, lay, cls, ok);
        checks++; if (!ok) begin errors++; $display("FAIL raw2_timeout got 0 exp 1"); end
        checks++; if (cnt !== 40'h9987_6543_21) begin errors++; $display("FAIL raw2_count got %h exp 9987654321", cnt); end
        checks++; if (cls !== 4'd8) begin errors++; $display("FAIL raw2_class got %0d exp 8", cls); end
    endtask

    task automatic test_backpressure();
        int k;
        a_load(9'h0AA, 9'h155, 9'h000, 9'h1FF, 4'd9, 4'd0, 4'd4, 4'd4,
               2'b01, 2'b10, 2'b10, 2'b01);
        a_out_ready = 1'b0;
        a_start(9'h0AA);
        k = 0;
        while (!a_out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL bp_timeout got %b exp 1", a_out_valid); end
        for (int i = 0; i < 10; i++) begin
            a_in_valid = (i % 2 == 0);
            a_layer_in = 9'h1FF;
            @(negedge clk);
            checks++; if ({a_out_valid, a_in_ready, a_w_rd} !== 3'b100) begin errors++; $display("FAIL bp_ctrl cycle %0d got %b exp 100", i, {a_out_valid, a_in_ready, a_w_rd}); end
            checks++; if ({a_count, a_layer_out} !== {16'h4509, 4'b1011}) begin errors++; $display("FAIL bp_hold cycle %0d got %h exp 45090b", i, {a_count, a_layer_out}); end
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        @(negedge clk);
        checks++; if ({a_out_valid, a_in_ready} !== 2'b01) begin errors++; $display("FAIL bp_release got %b exp 01", {a_out_valid, a_in_ready}); end
        @(negedge clk);
        checks++; if ({a_w_rd, a_state} !== 3'b000) begin errors++; $display("FAIL bp_no_queue got %b exp 000", {a_w_rd, a_state}); end
    endtask

    task automatic test_mid_reset();
        logic [15:0] cnt;
        logic [3:0]  lay;
        logic        ok;
        a_out_ready = 1'b1;
        a_start(9'h0AA);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if ({a_out_valid, a_w_rd, a_in_ready} !== 3'b001) begin errors++; $display("FAIL mrst_ctrl got %b exp 001", {a_out_valid, a_w_rd, a_in_ready}); end
        checks++; if (a_count !== 16'h0) begin errors++; $display("FAIL mrst_count got %h exp 0", a_count); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++; if ({a_out_valid, a_w_rd, a_state} !== 4'b0000) begin errors++; $display("FAIL mrst_idle cycle %0d got %b exp 0000", i, {a_out_valid, a_w_rd, a_state}); end
        end
        a_run(9'h0AA, cnt, lay, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mrst_next_timeout got 0 exp 1"); end
        checks++; if (cnt !== 16'h4509) begin errors++; $display("FAIL mrst_next_count got %h exp 4509", cnt); end
        checks++; if (lay !== 4'b1011) begin errors++; $display("FAIL mrst_next_layer got %b exp 1011", lay); end
    endtask

    initial begin
        rst         = 1'b1;
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        a_layer_in  = '0;
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        b_layer_in  = '0;
        test_reset();
        test_latency();
        test_sign_codes();
        test_pattern();
        test_raw();
        test_backpressure();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
